hack_uart_loader: RTL and testbench
===================================

# hack_uart_loader

UART program loader for the Basys3 Hack PC: receives a length-prefixed word stream over a UART 8N1 serial line and writes it into instruction memory starting at address 0. It is the writer side of the instruction ROM, which the CPU only reads. While a load is in progress it holds the CPU in reset through `cpu_hold`, which the top level ORs into the CPU reset. On completion it releases the CPU so the new program runs from address 0.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4 and even.
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: asynchronous, active-high reset.
- `rx` input 1: UART serial input, idle high, asynchronous to `clk`.
- `load_req` input 1: debounced request level; starts a load when seen high in IDLE.
- `rom_we` output 1: one-cycle write strobe to instruction memory.
- `rom_addr` output 15: write address.
- `rom_wdata` output 16: write data.
- `cpu_hold` output 1: hold CPU in reset.
- `busy` output 1: loader is not in IDLE.
- `done` output 1: one-cycle pulse when a load completes successfully.
- `err` output 1: sticky error flag; cleared when the next load starts.
- `words_loaded` output 16: number of words written in the current or last load.

## Operation
- `rx` passes through a 2-FF synchronizer before any use.
- Receiver FSM:
  - RX_IDLE: on synchronized `rx`==0, clear the bit counter and go to RX_START.
  - RX_START: at CLKS_PER_BIT/2 cycles, if `rx`==0 go to RX_DATA; otherwise it was a glitch, return to RX_IDLE with no error.
  - RX_DATA: sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
  - RX_STOP: sample CLKS_PER_BIT cycles after bit 7. If `rx`==1, issue a one-cycle `byte_valid` with the byte. If `rx`==0, issue a one-cycle `frame_err`. Either way, return to RX_IDLE.
- Words are big-endian: high byte first, then low byte.
- Loader FSM:
  - L_IDLE: `cpu_hold`=0. If `load_req`=1, set `cpu_hold`=1, `err`=0, `words_loaded`=0, `rom_addr`=0, and go to L_LEN_HI.
  - L_LEN_HI / L_LEN_LO: assemble the 16-bit length N.
  - On the L_LEN_LO byte: N=0 or N>32768 goes to L_ERR. Otherwise go to L_DATA_HI.
  - L_DATA_HI / L_DATA_LO: assemble the word into `rom_wdata`.
  - On the L_DATA_LO byte, go to L_WRITE.
  - L_WRITE: one cycle with `rom_we`=1 at the current `rom_addr`. Next cycle: `rom_addr`+1 and `words_loaded`+1. If the new count equals N, go to L_DONE; otherwise go to L_DATA_HI.
  - L_DONE: `done`=1 for one cycle and `cpu_hold` drops in the same cycle; go to L_IDLE.
  - L_ERR: `err`=1 and `cpu_hold`=1 (never run a partial program). If `load_req`=1, restart exactly as from L_IDLE.
- `frame_err` in any state except L_IDLE/L_ERR goes to L_ERR. Bytes arriving in L_IDLE/L_ERR are discarded.
- `load_req` while busy is ignored.
- Widths: `rom_addr` wraps modulo 2^15, but reaching 32768 words always terminates via N first. `words_loaded` is 16 bit and reaches 32768 without overflow.
- Reset values: `rom_we`=0, `rom_addr`=0, `rom_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0, `words_loaded`=0. Both FSMs return to their IDLE state.

## Timing
- Reset is asynchronous assert; release is synchronous to `clk` at the top level.
- A mid-load reset aborts immediately. Memory content already written is left as is.
- `byte_valid` fires 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the start-bit falling edge, within ±1 cycle of the sync jitter.
- Low data byte `byte_valid` at cycle T:
  - state L_WRITE and `rom_we`=1 at T+1;
  - `rom_addr`/`words_loaded` update at T+2;
  - `done` at T+2 for the last word.
- `cpu_hold` rises the cycle after `load_req` is sampled high in L_IDLE and stays high continuously until the `done` cycle.
- `rom_wdata` and `rom_addr` are stable throughout the `rom_we` cycle. The memory latches them on that edge.
- Back-to-back bytes with zero idle between the stop bit and the next start bit must be accepted.

## Test plan
- Use CLKS_PER_BIT=4. Assert `load_req`, then send 00 02 12 34 AB CD:
  - `rom_we` pulses twice: addr 0/data 0x1234, then addr 1/data 0xABCD;
  - `done` pulses once, `words_loaded`=2, `cpu_hold` 1→0 on `done`.
- Length 00 00: `err`=1, `cpu_hold` stays 1, no `rom_we`. A following `load_req` with a valid 1-word stream clears `err` and loads address 0.
- Send a byte with stop bit 0 during the second data word: `err`=1, exactly one `rom_we` seen, `cpu_hold`=1, `done` never pulses.
- Pull `rx` low for 1 cycle only (glitch): no `byte_valid`, FSM state unchanged, no error.
- Assert `reset` after 3 bytes of a load: all outputs return to reset values immediately. A fresh load afterwards writes starting at address 0.
- Send bytes while in L_IDLE without `load_req`: no `rom_we`, `busy`=0, `cpu_hold`=0.

Source files
------------

// File: rtl/hack_uart_loader_if.sv
// -----------------------------------------------------------------------------
// hack_uart_loader_if
//   Write port of the Hack instruction memory. The UART loader drives it as
//   master. The instruction memory receives it as slave and latches address
//   and data on the clock edge that ends a cycle with rom_we high.
//
//   rom_we    : one-cycle write strobe
//   rom_addr  : 15-bit word address
//   rom_wdata : 16-bit instruction word
// -----------------------------------------------------------------------------
interface hack_uart_loader_if;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  modport master (output rom_we, rom_addr, rom_wdata);
  modport slave  (input  rom_we, rom_addr, rom_wdata);
endinterface

// File: rtl/hack_uart_loader.sv
// -----------------------------------------------------------------------------
// hack_uart_loader
//   Receives a length-prefixed, big-endian word stream over UART 8N1 and writes
//   it into instruction memory from address 0. The CPU is held in reset for the
//   whole load. It is released only when every announced word has been written.
//
//   Parameters
//     CLKS_PER_BIT : clock cycles per UART bit. Must be even and >= 4.
//   Ports
//     clk          : system clock
//     reset        : asynchronous, active-high reset
//     rx           : UART serial input, idle high, asynchronous to clk
//     load_req     : request level. Starts a load when seen in IDLE or ERR.
//     rom          : instruction-memory write port (master)
//     cpu_hold     : holds the CPU in reset while a load is pending or failed
//     busy         : loader FSM is not idle
//     done         : one-cycle pulse when a load completes
//     err          : sticky error. Cleared when the next load starts.
//     words_loaded : words written by the current or last load
// -----------------------------------------------------------------------------
module hack_uart_loader #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic               load_req,
  hack_uart_loader_if.master rom,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        words_loaded
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    L_IDLE,
    L_LEN_HI,
    L_LEN_LO,
    L_DATA_HI,
    L_DATA_LO,
    L_WRITE,
    L_DONE,
    L_ERR
  } ld_state_e;

  // ---------------------------------------------------------------------------
  // rx synchronizer
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the synchronizer resets to the line's idle level (1). A reset to 0
      // would look like a start bit the moment reset is released.
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments, so that
      // every register samples values from before the edge.
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver: samples the middle of each bit. The clock counter is
  // re-armed at the middle of the start bit.
  // ---------------------------------------------------------------------------
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       rx_byte_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            clk_cnt_q  <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (clk_cnt_q == CNT_HALF) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            // A start bit that is high again by mid-bit was only a glitch.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_q == CNT_FULL) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};  // LSB arrives first
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt_q == CNT_FULL) begin
            clk_cnt_q  <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              rx_byte_q    <= shift_q;
              byte_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  ld_state_e   ld_state_q;
  logic [15:0] len_q;
  logic        rom_we_q;
  logic [14:0] rom_addr_q;
  logic [15:0] rom_wdata_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] words_loaded_q;

  logic [15:0] words_d;   // count after the word now being written
  logic [15:0] len_d;     // length once the low byte is in
  logic        can_start;

  assign words_d   = words_loaded_q + 16'd1;
  assign len_d     = {len_q[15:8], rx_byte_q};
  assign can_start = (ld_state_q == L_IDLE) || (ld_state_q == L_ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state_q     <= L_IDLE;
      len_q          <= '0;
      rom_we_q       <= 1'b0;
      rom_addr_q     <= '0;
      rom_wdata_q    <= '0;
      cpu_hold_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
    end else if (frame_err_q && !can_start) begin
      // A corrupt byte means the program cannot be trusted. Keep the CPU held.
      ld_state_q <= L_ERR;
      err_q      <= 1'b1;
      cpu_hold_q <= 1'b1;
      rom_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else if (can_start && load_req) begin
      ld_state_q     <= L_LEN_HI;
      cpu_hold_q     <= 1'b1;
      err_q          <= 1'b0;
      words_loaded_q <= '0;
      rom_addr_q     <= '0;
    end else begin
      case (ld_state_q)
        L_LEN_HI: begin
          if (byte_valid_q) begin
            len_q[15:8] <= rx_byte_q;
            ld_state_q  <= L_LEN_LO;
          end
        end
        L_LEN_LO: begin
          if (byte_valid_q) begin
            len_q[7:0] <= rx_byte_q;
            if (len_d == 16'd0 || len_d > 16'd32768) begin
              err_q      <= 1'b1;
              ld_state_q <= L_ERR;
            end else begin
              ld_state_q <= L_DATA_HI;
            end
          end
        end
        L_DATA_HI: begin
          if (byte_valid_q) begin
            rom_wdata_q[15:8] <= rx_byte_q;
            ld_state_q        <= L_DATA_LO;
          end
        end
        L_DATA_LO: begin
          if (byte_valid_q) begin
            rom_wdata_q[7:0] <= rx_byte_q;
            rom_we_q         <= 1'b1;
            ld_state_q       <= L_WRITE;
          end
        end
        L_WRITE: begin
          // Address and data stay put during the strobe. They advance afterwards.
          rom_we_q       <= 1'b0;
          rom_addr_q     <= rom_addr_q + 15'd1;
          words_loaded_q <= words_d;
          if (words_d == len_q) begin
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            ld_state_q <= L_DONE;
          end else begin
            ld_state_q <= L_DATA_HI;
          end
        end
        L_DONE: begin
          done_q     <= 1'b0;
          ld_state_q <= L_IDLE;
        end
        L_ERR: begin
          err_q      <= 1'b1;
          cpu_hold_q <= 1'b1;
        end
        default: ; // L_IDLE: bytes are discarded
      endcase
    end
  end

  assign rom.rom_we    = rom_we_q;
  assign rom.rom_addr  = rom_addr_q;
  assign rom.rom_wdata = rom_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = (ld_state_q != L_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_hack_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_hack_uart_loader
//   Directed bench for hack_uart_loader with CLKS_PER_BIT=4. Serial stimulus is
//   driven on falling clock edges. A negedge monitor records every memory write
//   and every done pulse.
// -----------------------------------------------------------------------------
module tb_hack_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        load_req = 1'b0;
  logic        cpu_hold, busy, done, err;
  logic [15:0] words_loaded;

  hack_uart_loader_if rom_if ();

  hack_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .load_req     (load_req),
    .rom          (rom_if),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [14:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int done_cnt     = 0;
  int bv_cnt       = 0;
  int hold_in_done = 0;   // done cycles in which cpu_hold was still high
  int hold_gap     = 0;   // busy, non-done cycles in which cpu_hold was low

  always @(negedge clk) begin
    if (rom_if.rom_we) begin
      wr_addr.push_back(rom_if.rom_addr);
      wr_data.push_back(rom_if.rom_wdata);
    end
    if (done) begin
      done_cnt++;
      if (cpu_hold) hold_in_done++;
    end
    if (busy && !done && !cpu_hold) hold_gap++;
    if (dut.byte_valid_q) bv_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. These are called at a falling edge and return at one.
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int start;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != start) seen = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec_cnt++; if (busy !== 1'b0 || cpu_hold !== 1'b0) begin miss_cnt++;
      $display("FAIL rst_in_reset: busy=%b cpu_hold=%b, want 0 0", busy, cpu_hold); end
    reset = 1'b0;
    @(negedge clk);
    vec_cnt++; if (rom_if.rom_we !== 1'b0 || rom_if.rom_addr !== 15'd0 || rom_if.rom_wdata !== 16'd0) begin
      miss_cnt++; $display("FAIL rst_rom: we=%b addr=%h data=%h, want 0 0 0",
                           rom_if.rom_we, rom_if.rom_addr, rom_if.rom_wdata); end
    vec_cnt++; if ({cpu_hold, busy, done, err} !== 4'b0000) begin miss_cnt++;
      $display("FAIL rst_status: hold/busy/done/err=%b, want 0000", {cpu_hold, busy, done, err}); end
    vec_cnt++; if (words_loaded !== 16'd0) begin miss_cnt++;
      $display("FAIL rst_words: got %0d, want 0", words_loaded); end
  endtask

  task automatic test_idle_bytes();
    int w0, b0;
    w0 = wr_addr.size(); b0 = bv_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (6) @(negedge clk);
    vec_cnt++; if (bv_cnt - b0 !== 2) begin miss_cnt++;
      $display("FAIL idle_rx_bytes: got %0d bytes, want 2", bv_cnt - b0); end
    vec_cnt++; if (wr_addr.size() - w0 !== 0) begin miss_cnt++;
      $display("FAIL idle_no_write: got %0d writes, want 0", wr_addr.size() - w0); end
    vec_cnt++; if (busy !== 1'b0 || cpu_hold !== 1'b0) begin miss_cnt++;
      $display("FAIL idle_status: busy=%b cpu_hold=%b, want 0 0", busy, cpu_hold); end
  endtask

  task automatic test_basic_load();
    int w0, d0, h0, g0;
    bit seen;
    w0 = wr_addr.size(); d0 = done_cnt; h0 = hold_in_done; g0 = hold_gap;
    pulse_load();
    vec_cnt++; if (cpu_hold !== 1'b1 || busy !== 1'b1) begin miss_cnt++;
      $display("FAIL basic_hold_rise: cpu_hold=%b busy=%b, want 1 1", cpu_hold, busy); end
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    wait_done(12, seen);
    vec_cnt++; if (seen !== 1'b1) begin miss_cnt++;
      $display("FAIL basic_done_timeout: done seen=%b, want 1", seen); end
    repeat (4) @(negedge clk);
    vec_cnt++; if (wr_addr.size() - w0 !== 2) begin miss_cnt++;
      $display("FAIL basic_write_count: got %0d, want 2", wr_addr.size() - w0); end
    else begin
      vec_cnt++; if (wr_addr[w0] !== 15'd0 || wr_data[w0] !== 16'h1234) begin miss_cnt++;
        $display("FAIL basic_w0: addr=%h data=%h, want 0000 1234", wr_addr[w0], wr_data[w0]); end
      vec_cnt++; if (wr_addr[w0+1] !== 15'd1 || wr_data[w0+1] !== 16'hABCD) begin miss_cnt++;
        $display("FAIL basic_w1: addr=%h data=%h, want 0001 abcd", wr_addr[w0+1], wr_data[w0+1]); end
    end
    vec_cnt++; if (done_cnt - d0 !== 1) begin miss_cnt++;
      $display("FAIL basic_done_count: got %0d, want 1", done_cnt - d0); end
    vec_cnt++; if (words_loaded !== 16'd2 || rom_if.rom_addr !== 15'd2) begin miss_cnt++;
      $display("FAIL basic_counts: words=%0d addr=%0d, want 2 2", words_loaded, rom_if.rom_addr); end
    vec_cnt++; if (hold_in_done - h0 !== 0 || hold_gap - g0 !== 0) begin miss_cnt++;
      $display("FAIL basic_hold_shape: hold_in_done=%0d gaps=%0d, want 0 0",
               hold_in_done - h0, hold_gap - g0); end
    vec_cnt++; if (cpu_hold !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin miss_cnt++;
      $display("FAIL basic_end: cpu_hold=%b busy=%b err=%b, want 0 0 0", cpu_hold, busy, err); end
  endtask

  task automatic test_zero_len();
    int w0;
    bit seen;
    w0 = wr_addr.size();
    pulse_load();
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (8) @(negedge clk);
    vec_cnt++; if (err !== 1'b1 || cpu_hold !== 1'b1) begin miss_cnt++;
      $display("FAIL zlen_err: err=%b cpu_hold=%b, want 1 1", err, cpu_hold); end
    vec_cnt++; if (wr_addr.size() - w0 !== 0) begin miss_cnt++;
      $display("FAIL zlen_no_write: got %0d writes, want 0", wr_addr.size() - w0); end
    pulse_load();
    vec_cnt++; if (err !== 1'b0 || cpu_hold !== 1'b1) begin miss_cnt++;
      $display("FAIL zlen_restart: err=%b cpu_hold=%b, want 0 1", err, cpu_hold); end
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
    wait_done(12, seen);
    vec_cnt++; if (seen !== 1'b1) begin miss_cnt++;
      $display("FAIL zlen_retry_timeout: done seen=%b, want 1", seen); end
    repeat (4) @(negedge clk);
    vec_cnt++; if (wr_addr.size() - w0 !== 1) begin miss_cnt++;
      $display("FAIL zlen_retry_count: got %0d writes, want 1", wr_addr.size() - w0); end
    else begin
      vec_cnt++; if (wr_addr[w0] !== 15'd0 || wr_data[w0] !== 16'hBEEF) begin miss_cnt++;
        $display("FAIL zlen_retry_w0: addr=%h data=%h, want 0000 beef", wr_addr[w0], wr_data[w0]); end
    end
    vec_cnt++; if (words_loaded !== 16'd1 || err !== 1'b0 || cpu_hold !== 1'b0) begin miss_cnt++;
      $display("FAIL zlen_retry_end: words=%0d err=%b cpu_hold=%b, want 1 0 0",
               words_loaded, err, cpu_hold); end
  endtask

  task automatic test_glitch();
    int w0, b0;
    w0 = wr_addr.size(); b0 = bv_cnt;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    vec_cnt++; if (bv_cnt - b0 !== 0) begin miss_cnt++;
      $display("FAIL glitch_byte: got %0d bytes, want 0", bv_cnt - b0); end
    vec_cnt++; if (busy !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b0 || wr_addr.size() != w0) begin
      miss_cnt++; $display("FAIL glitch_state: busy=%b err=%b cpu_hold=%b, want 0 0 0",
                           busy, err, cpu_hold); end
    send_byte(8'h5A, 1'b1);
    repeat (6) @(negedge clk);
    vec_cnt++; if (bv_cnt - b0 !== 1) begin miss_cnt++;
      $display("FAIL glitch_recover: got %0d bytes, want 1", bv_cnt - b0); end
  endtask

  task automatic test_frame_err();
    int w0, d0;
    w0 = wr_addr.size(); d0 = done_cnt;
    pulse_load();
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b0);
    repeat (12) @(negedge clk);
    vec_cnt++; if (err !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b1) begin miss_cnt++;
      $display("FAIL ferr_status: err=%b cpu_hold=%b busy=%b, want 1 1 1", err, cpu_hold, busy); end
    vec_cnt++; if (wr_addr.size() - w0 !== 1) begin miss_cnt++;
      $display("FAIL ferr_write_count: got %0d, want 1", wr_addr.size() - w0); end
    else begin
      vec_cnt++; if (wr_addr[w0] !== 15'd0 || wr_data[w0] !== 16'h1122) begin miss_cnt++;
        $display("FAIL ferr_w0: addr=%h data=%h, want 0000 1122", wr_addr[w0], wr_data[w0]); end
    end
    vec_cnt++; if (done_cnt - d0 !== 0) begin miss_cnt++;
      $display("FAIL ferr_no_done: got %0d done pulses, want 0", done_cnt - d0); end
  endtask

  task automatic test_bad_len();
    int w0;
    w0 = wr_addr.size();
    pulse_load();
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++;
      $display("FAIL blen_clear: err=%b, want 0", err); end
    send_byte(8'h80, 1'b1); send_byte(8'h01, 1'b1);
    repeat (8) @(negedge clk);
    vec_cnt++; if (err !== 1'b1 || cpu_hold !== 1'b1 || wr_addr.size() != w0) begin miss_cnt++;
      $display("FAIL blen_err: err=%b cpu_hold=%b writes=%0d, want 1 1 0",
               err, cpu_hold, wr_addr.size() - w0); end
  endtask

  task automatic test_reset_midload();
    int w0;
    bit seen;
    pulse_load();
    send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'hAA, 1'b1);
    repeat (4) @(negedge clk);
    vec_cnt++; if (rom_if.rom_wdata[15:8] !== 8'hAA || busy !== 1'b1) begin miss_cnt++;
      $display("FAIL mid_pre: wdata=%h busy=%b, want aaxx 1", rom_if.rom_wdata, busy); end
    #2 reset = 1'b1;
    #1;
    vec_cnt++; if (rom_if.rom_we !== 1'b0 || rom_if.rom_addr !== 15'd0 || rom_if.rom_wdata !== 16'd0) begin
      miss_cnt++; $display("FAIL mid_rst_rom: we=%b addr=%h data=%h, want 0 0 0",
                           rom_if.rom_we, rom_if.rom_addr, rom_if.rom_wdata); end
    vec_cnt++; if ({cpu_hold, busy, done, err} !== 4'b0000 || words_loaded !== 16'd0) begin miss_cnt++;
      $display("FAIL mid_rst_status: hold/busy/done/err=%b words=%0d, want 0000 0",
               {cpu_hold, busy, done, err}, words_loaded); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    w0 = wr_addr.size();
    pulse_load();
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'hC0, 1'b1); send_byte(8'hDE, 1'b1);
    wait_done(12, seen);
    vec_cnt++; if (seen !== 1'b1) begin miss_cnt++;
      $display("FAIL mid_fresh_timeout: done seen=%b, want 1", seen); end
    repeat (4) @(negedge clk);
    vec_cnt++; if (wr_addr.size() - w0 !== 1) begin miss_cnt++;
      $display("FAIL mid_fresh_count: got %0d writes, want 1", wr_addr.size() - w0); end
    else begin
      vec_cnt++; if (wr_addr[w0] !== 15'd0 || wr_data[w0] !== 16'hC0DE) begin miss_cnt++;
        $display("FAIL mid_fresh_w0: addr=%h data=%h, want 0000 c0de", wr_addr[w0], wr_data[w0]); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_bytes();
    test_basic_load();
    test_zero_len();
    test_glitch();
    test_frame_err();
    test_bad_len();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
